// File: rtl/tile_uart_serializer.sv
// rtl/tile_uart_serializer.sv - BMEM tile readback serializer onto the UART write path
//
// Purpose:
//   Reads one tile group (MESHUNITS^2 * TILEUNITS^2 words) from BMEM on a start
//   pulse. It then takes the UART write lock and streams the tile out as a byte
//   frame that mirrors the loader's BMEM write frame:
//     0x80, B address bytes (LSB first), WORDS*B data bytes (word 0 first, LSB first)
//   Optional macro TILE_UART_CHECKSUM_EN appends one XOR checksum byte covering
//   every preceding frame byte.
//
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   start, addr        one-cycle dump request and the BMEM tile address it carries
//   busy, done         busy from accepted start until done; done is a one-cycle pulse
//   bmem_addr          registered BMEM read address (holds until the next accepted start)
//   bmem_data          flat tile, word i at [i*BITWIDTH +: BITWIDTH]
//   write_lock_req/res UART write lock request / grant
//   write_ready        UART accepts a byte this cycle
//   write_data(_valid) byte to UART and its valid
module tile_uart_serializer #(
    parameter int BITWIDTH          = 32,
    parameter int MESHUNITS         = 2,
    parameter int TILEUNITS         = 2,
    parameter int BMEM_READ_LATENCY = 1
) (
    input  logic                                                     clock,
    input  logic                                                     reset,
    input  logic                                                     start,
    input  logic [BITWIDTH-1:0]                                      addr,
    output logic                                                     busy,
    output logic                                                     done,
    output logic [BITWIDTH-1:0]                                      bmem_addr,
    input  logic [BITWIDTH*MESHUNITS*MESHUNITS*TILEUNITS*TILEUNITS-1:0] bmem_data,
    output logic                                                     write_lock_req,
    input  logic                                                     write_lock_res,
    input  logic                                                     write_ready,
    output logic [7:0]                                               write_data,
    output logic                                                     write_data_valid
);
    localparam int B        = BITWIDTH / 8;
    localparam int WORDS    = MESHUNITS * MESHUNITS * TILEUNITS * TILEUNITS;
    localparam int DATA_LEN = 1 + B + B * WORDS;
`ifdef TILE_UART_CHECKSUM_EN
    localparam int FRAME_LEN = DATA_LEN + 1;
`else
    localparam int FRAME_LEN = DATA_LEN;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam int LAT_W = $clog2(BMEM_READ_LATENCY + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_LOCK    = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    logic [2:0]                  state_q;
    logic                        busy_q;
    logic                        done_q;
    logic [BITWIDTH-1:0]         bmem_addr_q;
    logic [BITWIDTH*WORDS-1:0]   buf_q;
    logic [LAT_W-1:0]            lat_q;
    logic [CNT_W-1:0]            cnt_q;
    logic                        req_q;
    logic [7:0]                  wdata_q;
    logic                        wvalid_q;
`ifdef TILE_UART_CHECKSUM_EN
    logic [7:0]                  csum_q;
`endif

    // Header, address and captured tile laid out as one byte-addressable
    // vector, so the byte counter indexes it directly.
    logic [8*DATA_LEN-1:0] frame_bits;
    logic [CNT_W-1:0]      cnt_d;
    logic [CNT_W-1:0]      sel;
    logic [7:0]            byte_d;

    assign frame_bits = {buf_q, bmem_addr_q, 8'h80};

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        // Keep the part-select in range when the next byte is the checksum.
        sel    = (cnt_d < CNT_W'(DATA_LEN)) ? cnt_d : '0;
        byte_d = frame_bits[{sel, 3'b000} +: 8];
`ifdef TILE_UART_CHECKSUM_EN
        // The running XOR excludes the byte being transferred now, so fold it in.
        if (cnt_d == CNT_W'(DATA_LEN)) begin
            byte_d = csum_q ^ wdata_q;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bmem_addr_q <= '0;
            buf_q       <= '0;
            lat_q       <= '0;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            wdata_q     <= 8'h00;
            wvalid_q    <= 1'b0;
`ifdef TILE_UART_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        bmem_addr_q <= addr;
                        busy_q      <= 1'b1;
                        lat_q       <= '0;
                        state_q     <= S_READ;
                    end
                end
                S_READ: begin
                    // Capture once the read latency has elapsed after bmem_addr settled;
                    // the buffer then isolates the frame from later BMEM writes.
                    if (lat_q == LAT_W'(BMEM_READ_LATENCY)) begin
                        buf_q   <= bmem_data;
                        req_q   <= 1'b1;
                        state_q <= S_LOCK;
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                S_LOCK: begin
                    if (write_lock_res) begin
                        wdata_q  <= 8'h80;
                        wvalid_q <= 1'b1;
                        cnt_q    <= '0;
`ifdef TILE_UART_CHECKSUM_EN
                        csum_q   <= 8'h00;
`endif
                        state_q  <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (write_ready) begin
`ifdef TILE_UART_CHECKSUM_EN
                        csum_q <= csum_q ^ wdata_q;
`endif
                        if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                            wvalid_q <= 1'b0;
                            state_q  <= S_RELEASE;
                        end else begin
                            cnt_q   <= cnt_d;
                            wdata_q <= byte_d;
                        end
                    end
                end
                S_RELEASE: begin
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign bmem_addr        = bmem_addr_q;
    assign write_lock_req   = req_q;
    assign write_data       = wdata_q;
    assign write_data_valid = wvalid_q;
endmodule

// File: tb/tb_tile_uart_serializer.sv
// tb/tb_tile_uart_serializer.sv - self-checking bench for tile_uart_serializer
module tb_tile_uart_serializer;
    localparam int B     = 4;
    localparam int WORDS = 16;
`ifdef TILE_UART_CHECKSUM_EN
    localparam int FLEN = 70;
`else
    localparam int FLEN = 69;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [31:0]  addr = 32'h0;
    logic         busy, done;
    logic [31:0]  bmem_addr;
    logic [511:0] bmem_data = '0;
    logic         write_lock_req;
    logic         write_lock_res = 1'b0;
    logic         write_ready = 1'b0;
    logic [7:0]   write_data;
    logic         write_data_valid;

    tile_uart_serializer dut (
        .clock(clock), .reset(reset), .start(start), .addr(addr),
        .busy(busy), .done(done), .bmem_addr(bmem_addr), .bmem_data(bmem_data),
        .write_lock_req(write_lock_req), .write_lock_res(write_lock_res),
        .write_ready(write_ready), .write_data(write_data),
        .write_data_valid(write_data_valid)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    byte unsigned exp_q[$];
    int   n_xfer = 0;
    int   n_done = 0;
    logic bp_mode = 1'b0;
    int   lock_delay = 0;
    int   lock_cnt = 0;
    logic held_pending = 1'b0;
    logic [7:0] held_byte = 8'h00;
    logic [7:0] last_byte = 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Lock arbiter and ready pattern, driven just after each rising edge.
    initial forever begin
        @(posedge clock);
        #1;
        if (reset || !write_lock_req) begin
            write_lock_res = 1'b0;
            lock_cnt       = 0;
        end else if (!write_lock_res) begin
            if (lock_cnt >= lock_delay) write_lock_res = 1'b1;
            else lock_cnt++;
        end
        write_ready = bp_mode ? ~write_ready : 1'b1;
    end

    // Monitor on the falling edge: a byte with valid&&ready here transfers at the next rise.
    initial forever begin
        @(negedge clock);
        if (!reset) begin
            if (!write_lock_res) check("valid_before_grant", 64'(write_data_valid), 64'd0);
            if (held_pending && write_data_valid) check("held_stable", 64'(write_data), 64'(held_byte));
            held_pending = write_data_valid && !write_ready;
            held_byte    = write_data;
            if (write_data_valid && write_ready) begin
                if (exp_q.size() == 0) check("extra_byte", 64'd1, 64'd0);
                else check($sformatf("byte%0d", n_xfer), 64'(write_data), 64'(exp_q.pop_front()));
                last_byte = write_data;
                n_xfer++;
            end
            if (done) n_done++;
        end else begin
            held_pending = 1'b0;
        end
    end

    task automatic push_frame(input logic [31:0] a, input logic [511:0] d);
        byte unsigned x;
        x = 8'h80;
        exp_q.push_back(8'h80);
        for (int i = 0; i < B; i++) begin
            exp_q.push_back(a[i*8 +: 8]);
            x ^= a[i*8 +: 8];
        end
        for (int i = 0; i < B * WORDS; i++) begin
            exp_q.push_back(d[i*8 +: 8]);
            x ^= d[i*8 +: 8];
        end
`ifdef TILE_UART_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    function automatic logic [511:0] make_data(input int kind);
        logic [511:0] d;
        for (int i = 0; i < WORDS; i++) begin
            case (kind)
                0:       d[i*32 +: 32] = 32'(i);
                1:       d[i*32 +: 32] = 32'hFFFF_FFFF;
                default: d[i*32 +: 32] = 32'hA5C3_0000 ^ (32'(i) * 32'h0101_0101);
            endcase
        end
        return d;
    endfunction

    typedef struct {
        logic [31:0] a;
        int          kind;
        int          ldly;
        logic        bp;
        int          extra_at;   // cycle of a second start while busy, -1 for none
        int          exp_len;
        int          exp_done;
        logic [31:0] exp_baddr;
    } vec_t;

    // Runs one frame and compares length, done count, drained scoreboard and idle state.
    task automatic run_frame(input vec_t v, input string tag);
        logic [511:0] d;
        d = make_data(v.kind);
        bmem_data  = d;
        lock_delay = v.ldly;
        bp_mode    = v.bp;
        n_xfer     = 0;
        n_done     = 0;
        exp_q.delete();
        push_frame(v.a, d);
        @(posedge clock); #1;
        addr  = v.a;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int c = 0; c < 2000 && n_done == 0; c++) begin
            @(posedge clock); #1;
            start = (c == v.extra_at);
            addr  = (c == v.extra_at) ? 32'h20 : v.a;
        end
        start = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        check({tag, "_len"},   64'(n_xfer), 64'(v.exp_len));
        check({tag, "_done"},  64'(n_done), 64'(v.exp_done));
        check({tag, "_left"},  64'(exp_q.size()), 64'd0);
        check({tag, "_busy"},  64'(busy), 64'd0);
        check({tag, "_req"},   64'(write_lock_req), 64'd0);
        check({tag, "_baddr"}, 64'(bmem_addr), 64'(v.exp_baddr));
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{32'h10,        0, 0, 1'b0, -1, FLEN, 1, 32'h10};
        vecs[1] = '{32'h10,        0, 5, 1'b0, -1, FLEN, 1, 32'h10};
        vecs[2] = '{32'h10,        0, 0, 1'b1, -1, FLEN, 1, 32'h10};
        vecs[3] = '{32'h10,        0, 0, 1'b0, 30, FLEN, 1, 32'h10};
        vecs[4] = '{32'hDEAD_BEEF, 2, 2, 1'b1, -1, FLEN, 1, 32'hDEAD_BEEF};

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_done",  64'(done), 64'd0);
        check("rst_baddr", 64'(bmem_addr), 64'd0);
        check("rst_req",   64'(write_lock_req), 64'd0);
        check("rst_wdata", 64'(write_data), 64'd0);
        check("rst_valid", 64'(write_data_valid), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_frame(vecs[i], $sformatf("v%0d", i));

        // Reset in the middle of the data bytes, then a clean frame.
        begin
            logic [511:0] d;
            int c;
            d = make_data(0);
            bmem_data  = d;
            lock_delay = 0;
            bp_mode    = 1'b0;
            n_xfer     = 0;
            n_done     = 0;
            exp_q.delete();
            push_frame(32'h10, d);
            @(posedge clock); #1;
            addr  = 32'h10;
            start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
            c = 0;
            while (n_xfer < 30 && c < 500) begin
                @(posedge clock); #1;
                c++;
            end
            check("mid_reached30", 64'(n_xfer), 64'd30);
            reset = 1'b1;
            start = 1'b1;
            @(posedge clock); #1;
            reset = 1'b0;
            start = 1'b0;
            check("mid_req",   64'(write_lock_req), 64'd0);
            check("mid_valid", 64'(write_data_valid), 64'd0);
            check("mid_busy",  64'(busy), 64'd0);
            check("mid_done",  64'(done), 64'd0);
            repeat (6) @(posedge clock);
            @(negedge clock);
            check("mid_nodone", 64'(n_done), 64'd0);
            check("mid_idle",   64'(busy), 64'd0);
        end
        run_frame(vecs[0], "after_rst");

`ifdef TILE_UART_CHECKSUM_EN
        begin
            vec_t cv;
            cv = '{32'h0, 1, 0, 1'b0, -1, 70, 1, 32'h0};
            run_frame(cv, "csum");
            check("csum_last", 64'(last_byte), 64'h80);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
